noc_host_injector: RTL and testbench

- Host-side endpoint on the CONNECT NoC that drives the layer chain.
- Buffers packed 7.9 sample/error vectors, injects them as single-flit packets to the first layer (forward) or last layer (backprop), and collects the flits returned by the chain.
- Enforces credit-based flow control toward its router, bounds outstanding packets, and detects lost or spurious returns.

---
 rtl/noc_host_injector_pkg.sv | 17 +
 rtl/noc_host_injector_if.sv | 24 ++
 rtl/noc_sync_fifo.sv | 37 +++
 rtl/noc_host_injector.sv | 88 ++++++++
 tb/tb_noc_host_injector.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_host_injector_pkg.sv
// noc_host_injector_pkg: shared NoC flit geometry, field offsets and host FSM states
package noc_host_injector_pkg;
  localparam int NUM_USER_RECV_PORTS = 4;
  localparam int FLIT_DATA_WIDTH = 17;
  localparam int DEST_BITS = $clog2(NUM_USER_RECV_PORTS);
  localparam int FLIT_W = 2 + FLIT_DATA_WIDTH + DEST_BITS + 2;
  localparam int DATA_W = FLIT_DATA_WIDTH - 1;
  localparam int BP_BIT = DATA_W;
  localparam int VC_LSB = DATA_W + 1;
  localparam int DEST_LSB = DATA_W + 3;
  localparam int TAIL_BIT = FLIT_W - 2;
  localparam int VALID_BIT = FLIT_W - 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, ERROR} state_t;
  function automatic logic [FLIT_W-1:0] make_flit(logic [DEST_BITS-1:0] dest, logic bp, logic [DATA_W-1:0] data);
    return {1'b1, 1'b1, dest, 2'b00, bp, data};
  endfunction
endpackage

// File: rtl/noc_host_injector_if.sv
// noc_host_injector_if: load, flit and result handshakes of the host endpoint
interface noc_host_injector_if;
  import noc_host_injector_pkg::*;
  logic load_valid;
  logic load_backprop;
  logic [DATA_W-1:0] load_data;
  logic load_ready;
  logic send_flit;
  logic [FLIT_W-1:0] flit_out;
  logic credit_in;
  logic recv_flit;
  logic [FLIT_W-1:0] flit_in;
  logic result_valid;
  logic result_backprop;
  logic [DATA_W-1:0] result_data;
  modport master (
    input load_valid, load_backprop, load_data, credit_in, flit_in,
    output load_ready, send_flit, flit_out, recv_flit, result_valid, result_backprop, result_data
  );
  modport slave (
    output load_valid, load_backprop, load_data, credit_in, flit_in,
    input load_ready, send_flit, flit_out, recv_flit, result_valid, result_backprop, result_data
  );
endinterface

// File: rtl/noc_sync_fifo.sv
// noc_sync_fifo: single-clock FIFO, power-of-2 depth, push ignored when full, pop ignored when empty
module noc_sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8
) (
  input  logic Clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge Clk) if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge Clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/noc_host_injector.sv
// noc_host_injector: host endpoint injecting buffered vectors into the layer chain and collecting returns
module noc_host_injector import noc_host_injector_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int INIT_CREDITS = 2,
  parameter int MAX_OUTSTANDING = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic Clk,
  input  logic reset,
  input  logic enable,
  input  logic [DEST_BITS-1:0] dest_first,
  input  logic [DEST_BITS-1:0] dest_last,
  noc_host_injector_if.master bus,
  output logic busy,
  output logic err_timeout,
  output logic err_spurious
);
  localparam int CW = $clog2(INIT_CREDITS + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [CW:0] CRED_MAX = (CW+1)'(INIT_CREDITS);
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT - 1);
  state_t state, next_state;
  logic [CW-1:0] credits;
  logic [OW-1:0] outstanding;
  logic [TW-1:0] timer;
  logic [CW:0] cred_sum;
  logic [DATA_W:0] head;
  logic full, empty;
  logic [$clog2(DEPTH):0] count;
  logic inject, ret_valid, good_ret, timeout_hit;
  logic unused_flit_bits;
  noc_sync_fifo #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_fifo (
    .Clk(Clk),
    .reset(reset),
    .push(bus.load_valid),
    .pop(inject),
    .din({bus.load_backprop, bus.load_data}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign unused_flit_bits = ^bus.flit_in[TAIL_BIT:VC_LSB];
  assign bus.load_ready = !full;
  assign bus.recv_flit = state != ERROR;
  assign busy = count != '0 || outstanding != '0;
  assign inject = state == RUN && enable && !empty && credits != '0 && outstanding < OUT_MAX;
  assign ret_valid = bus.flit_in[VALID_BIT] && state != ERROR;
  assign good_ret = ret_valid && outstanding != '0;
  // a return arriving on the deadline cycle still rescues the packet
  assign timeout_hit = (state == RUN || state == DRAIN) && timer == TIMER_END && !good_ret;
  assign cred_sum = {1'b0, credits} + (CW+1)'(bus.credit_in) - (CW+1)'(inject);
  always_comb begin
    next_state = timeout_hit ? ERROR
      : state == IDLE  ? (enable ? RUN : IDLE)
      : state == RUN   ? (enable ? RUN : outstanding != '0 ? DRAIN : IDLE)
      : state == DRAIN ? (outstanding == '0 ? IDLE : enable ? RUN : DRAIN)
      : ERROR;
  end
  always_ff @(posedge Clk) begin
    if (reset) begin
      state <= IDLE;
      credits <= CW'(INIT_CREDITS);
      outstanding <= '0;
      timer <= '0;
      bus.send_flit <= 1'b0;
      bus.flit_out <= '0;
      bus.result_valid <= 1'b0;
      bus.result_backprop <= 1'b0;
      bus.result_data <= '0;
      err_timeout <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      state <= next_state;
      credits <= CW'(cred_sum > CRED_MAX ? CRED_MAX : cred_sum);
      outstanding <= outstanding + OW'(inject) - OW'(good_ret);
      timer <= (good_ret || outstanding == '0) ? '0 : timer + 1'b1;
      bus.send_flit <= inject;
      bus.flit_out <= inject ? make_flit(head[DATA_W] ? dest_last : dest_first, head[DATA_W], head[DATA_W-1:0]) : '0;
      bus.result_valid <= good_ret;
      if (good_ret) {bus.result_backprop, bus.result_data} <= bus.flit_in[DATA_W:0];
      err_timeout <= err_timeout || timeout_hit;
      err_spurious <= err_spurious || (ret_valid && !good_ret);
    end
  end
endmodule

// File: tb/tb_noc_host_injector.sv
// tb_noc_host_injector: directed stimulus checked every cycle against a queue-based behavioural model
module tb_noc_host_injector;
  import noc_host_injector_pkg::*;
  localparam int DEPTH = 8;
  localparam int INIT_CREDITS = 2;
  localparam int MAX_OUT = 4;
  localparam int TIMEOUT = 48;
  logic Clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [DEST_BITS-1:0] dest_first = 1;
  logic [DEST_BITS-1:0] dest_last = 3;
  logic busy, err_timeout, err_spurious;
  int checks = 0;
  int errors = 0;
  int sent_total = 0;
  logic [FLIT_W-1:0] sent_q[$];
  logic [DATA_W:0] mq[$];
  int m_cred, m_out, m_tmr, m_mode;
  logic m_send, m_rv, m_rbp, m_et, m_es;
  logic [FLIT_W-1:0] m_flit;
  logic [DATA_W-1:0] m_rdata;
  noc_host_injector_if bus();
  noc_host_injector #(
    .DEPTH(DEPTH), .INIT_CREDITS(INIT_CREDITS), .MAX_OUTSTANDING(MAX_OUT), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk(Clk),
    .reset(reset),
    .enable(enable),
    .dest_first(dest_first),
    .dest_last(dest_last),
    .bus(bus),
    .busy(busy),
    .err_timeout(err_timeout),
    .err_spurious(err_spurious)
  );
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model modes: 0 idle, 1 run, 2 drain, 3 error
  always @(posedge Clk) begin
    if (reset) begin
      mq.delete();
      m_cred = INIT_CREDITS; m_out = 0; m_tmr = 0; m_mode = 0;
      m_send = 0; m_flit = '0; m_rv = 0; m_rbp = 0; m_rdata = '0; m_et = 0; m_es = 0;
    end else begin
      bit inj, pu, rv, good, tmo;
      logic [DATA_W:0] h;
      inj = m_mode == 1 && enable && mq.size() > 0 && m_cred > 0 && m_out < MAX_OUT;
      pu = bus.load_valid && mq.size() < DEPTH;
      rv = bus.flit_in[FLIT_W-1] && m_mode != 3;
      good = rv && m_out > 0;
      tmo = (m_mode == 1 || m_mode == 2) && m_tmr == TIMEOUT - 1 && !good;
      m_send = inj;
      m_flit = '0;
      if (inj) begin
        h = mq.pop_front();
        m_flit = {2'b11, h[DATA_W] ? dest_last : dest_first, 2'b00, h};
      end
      if (pu) mq.push_back({bus.load_backprop, bus.load_data});
      m_tmr = (good || m_out == 0) ? 0 : m_tmr + 1;
      m_cred = m_cred - int'(inj) + int'(bus.credit_in);
      if (m_cred > INIT_CREDITS) m_cred = INIT_CREDITS;
      if (tmo) m_mode = 3;
      else if (m_mode == 0) m_mode = enable ? 1 : 0;
      else if (m_mode == 1) m_mode = enable ? 1 : (m_out > 0 ? 2 : 0);
      else if (m_mode == 2) m_mode = m_out == 0 ? 0 : (enable ? 1 : 2);
      m_out = m_out + int'(inj) - int'(good);
      m_rv = good;
      if (good) {m_rbp, m_rdata} = bus.flit_in[DATA_W:0];
      m_et = m_et || tmo;
      m_es = m_es || (rv && !good);
    end
    #1;
    chk("send_flit", bus.send_flit, m_send);
    chk("flit_out", bus.flit_out, m_flit);
    chk("result_valid", bus.result_valid, m_rv);
    chk("result_backprop", bus.result_backprop, m_rbp);
    chk("result_data", bus.result_data, m_rdata);
    chk("load_ready", bus.load_ready, mq.size() < DEPTH);
    chk("busy", busy, mq.size() > 0 || m_out > 0);
    chk("recv_flit", bus.recv_flit, m_mode != 3);
    chk("err_timeout", err_timeout, m_et);
    chk("err_spurious", err_spurious, m_es);
    if (bus.send_flit) begin
      sent_q.push_back(bus.flit_out);
      sent_total++;
    end
  end

  task automatic push_entry(input logic bp, input logic [DATA_W-1:0] d);
    bus.load_valid = 1'b1; bus.load_backprop = bp; bus.load_data = d;
    @(negedge Clk);
    bus.load_valid = 1'b0;
  endtask

  task automatic ret(input logic bp, input logic [DATA_W-1:0] d, input logic cr);
    bus.flit_in = make_flit('0, bp, d); bus.credit_in = cr;
    @(negedge Clk);
    bus.flit_in = '0; bus.credit_in = 1'b0;
  endtask

  task automatic wait_sent(output logic [FLIT_W-1:0] f);
    int n = 0;
    while (sent_q.size() == 0 && n < 64) begin
      @(negedge Clk);
      n++;
    end
    f = '0;
    if (sent_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL wait_sent: got no flit within 64 cycles, required one");
    end else f = sent_q.pop_front();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge Clk);
    reset = 1'b0;
    sent_q.delete();
  endtask

  initial begin
    logic [FLIT_W-1:0] f;
    int n0;
    bus.load_valid = 0; bus.load_backprop = 0; bus.load_data = '0; bus.credit_in = 0; bus.flit_in = '0;
    repeat (2) @(negedge Clk);
    chk("rst_load_ready", bus.load_ready, 1);
    chk("rst_recv_flit", bus.recv_flit, 1);
    chk("rst_busy", busy, 0);
    chk("rst_send", bus.send_flit, 0);
    chk("rst_flit_out", bus.flit_out, 0);
    chk("rst_errs", {err_timeout, err_spurious}, 0);
    reset = 1'b0;
    // forward single sample
    enable = 1'b1;
    @(negedge Clk);
    push_entry(0, 16'h1A2B);
    wait_sent(f);
    chk("fwd_dest", f[DEST_LSB +: DEST_BITS], 1);
    chk("fwd_bp", f[BP_BIT], 0);
    chk("fwd_data", f[DATA_W-1:0], 16'h1A2B);
    chk("fwd_valid_tail_vc", {f[VALID_BIT], f[TAIL_BIT], f[VC_LSB +: 2]}, 4'b1100);
    repeat (4) @(negedge Clk);
    ret(0, 16'h1A2B, 1);
    chk("fwd_result_valid", bus.result_valid, 1);
    chk("fwd_result_data", bus.result_data, 16'h1A2B);
    chk("fwd_busy", busy, 0);
    // credit stall, credit restore, simultaneous credit+inject, saturation
    n0 = sent_total;
    for (int i = 0; i < 4; i++) push_entry(0, DATA_W'(16'h0100 + i));
    repeat (8) @(negedge Clk);
    chk("stall_two_sent", sent_total - n0, 2);
    bus.credit_in = 1; @(negedge Clk); bus.credit_in = 0;
    repeat (3) @(negedge Clk);
    chk("stall_third_sent", sent_total - n0, 3);
    bus.credit_in = 1; repeat (2) @(negedge Clk); bus.credit_in = 0;
    repeat (3) @(negedge Clk);
    chk("stall_fourth_sent", sent_total - n0, 4);
    for (int i = 0; i < 4; i++) begin
      wait_sent(f);
      chk("stall_order", f[DATA_W-1:0], 16'h0100 + i);
    end
    for (int i = 0; i < 4; i++) ret(0, DATA_W'(16'h0100 + i), 0);
    push_entry(0, 16'h0110);
    push_entry(0, 16'h0111);
    repeat (6) @(negedge Clk);
    chk("credit_held_one", sent_total - n0, 5);
    wait_sent(f);
    ret(0, f[DATA_W-1:0], 1);
    wait_sent(f);
    chk("second_after_credit", f[DATA_W-1:0], 16'h0111);
    ret(0, f[DATA_W-1:0], 0);
    bus.credit_in = 1; repeat (4) @(negedge Clk); bus.credit_in = 0;
    for (int i = 0; i < 4; i++) push_entry(0, DATA_W'(16'h0120 + i));
    repeat (8) @(negedge Clk);
    chk("credit_saturate", sent_total - n0, 8);
    // reset mid-operation with queued and outstanding packets
    do_reset();
    chk("midrst_busy", busy, 0);
    chk("midrst_send", bus.send_flit, 0);
    repeat (3) @(negedge Clk);
    chk("midrst_no_emit", sent_q.size(), 0);
    // backprop routing
    @(negedge Clk);
    push_entry(1, 16'h0ABC);
    wait_sent(f);
    chk("bp_dest", f[DEST_LSB +: DEST_BITS], 3);
    chk("bp_bit", f[BP_BIT], 1);
    ret(1, 16'h0ABC, 1);
    chk("bp_result_bp", bus.result_backprop, 1);
    chk("bp_result_data", bus.result_data, 16'h0ABC);
    // FIFO full, ordering, push during pop
    enable = 1'b0;
    @(negedge Clk);
    for (int i = 0; i < 8; i++) push_entry(0, DATA_W'(16'h0200 + i));
    chk("full_not_ready", bus.load_ready, 0);
    push_entry(0, 16'h02FF);
    chk("full_still_not_ready", bus.load_ready, 0);
    enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wait_sent(f);
      chk("full_order", f[DATA_W-1:0], i < 8 ? 16'h0200 + i : 16'h02EE);
      bus.flit_in = make_flit('0, 0, f[DATA_W-1:0]); bus.credit_in = 1;
      if (i == 2) begin bus.load_valid = 1; bus.load_backprop = 0; bus.load_data = 16'h02EE; end
      @(negedge Clk);
      bus.flit_in = '0; bus.credit_in = 0; bus.load_valid = 0;
    end
    repeat (3) @(negedge Clk);
    chk("full_extra_dropped", sent_q.size(), 0);
    // spurious return
    ret(0, 16'h5555, 0);
    chk("spur_err", err_spurious, 1);
    chk("spur_no_result", bus.result_valid, 0);
    // drain
    push_entry(0, 16'h0300);
    wait_sent(f);
    enable = 1'b0;
    @(negedge Clk);
    push_entry(0, 16'h0301);
    repeat (4) @(negedge Clk);
    chk("drain_no_send", sent_q.size(), 0);
    ret(0, 16'h0300, 1);
    chk("drain_result", bus.result_valid, 1);
    repeat (3) @(negedge Clk);
    chk("idle_no_send", sent_q.size(), 0);
    chk("idle_busy_queued", busy, 1);
    enable = 1'b1;
    wait_sent(f);
    chk("resume_data", f[DATA_W-1:0], 16'h0301);
    ret(0, 16'h0301, 1);
    // timeout
    do_reset();
    chk("rst_clears_spur", err_spurious, 0);
    push_entry(0, 16'h0400);
    wait_sent(f);
    repeat (40) @(negedge Clk);
    chk("tmo_not_yet", err_timeout, 0);
    repeat (10) @(negedge Clk);
    chk("tmo_set", err_timeout, 1);
    chk("tmo_recv_low", bus.recv_flit, 0);
    push_entry(0, 16'h0401);
    ret(0, 16'h0400, 1);
    chk("tmo_return_dropped", bus.result_valid, 0);
    repeat (4) @(negedge Clk);
    chk("tmo_no_send", sent_q.size(), 0);
    do_reset();
    chk("tmo_rst_err", err_timeout, 0);
    chk("tmo_rst_recv", bus.recv_flit, 1);
    chk("tmo_rst_busy", busy, 0);
    @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
